// File: rtl/matmul_seq_ctrl.sv
// Sequencing controller for the matrix logic top: loads the X-buffer from a byte
// stream, runs the ALU to completion, then streams the result SRAM out word by word.
module matmul_seq_ctrl #(
    parameter int NUM_RESULTS = 32,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              input_load_en,
    output logic              valid_input,
    output logic [7:0]        X_load,
    input  logic              xload_done,
    output logic              ALU_en,
    input  logic              ALU_done,
    output logic              read_n,
    output logic [ADDR_W-1:0] r_addr,
    input  logic              ry,
    input  logic [8:0]        data_out,
    output logic              out_valid,
    output logic [8:0]        out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_RESULTS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [WAIT_W-1:0]   wait_q;
    logic                err_q;
    logic                done_q;
    logic                busy_q;
    logic                out_valid_q;
    logic [8:0]          out_data_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic                read_n_q;
    logic                alu_en_q;
    logic                load_en_q;

    logic                waiting;
    logic                advance;
    logic                wait_expired;

    // The wait counter only runs while stalled on an external event in one of the
    // three waiting states; the event arriving on the last cycle still wins.
    assign waiting      = (state_q == ST_LOAD) || (state_q == ST_COMPUTE) || (state_q == ST_RD_WAIT);
    assign advance      = ((state_q == ST_LOAD)    && xload_done) ||
                          ((state_q == ST_COMPUTE) && ALU_done)   ||
                          ((state_q == ST_RD_WAIT) && ry);
    assign wait_expired = waiting && !advance && (wait_q == WAIT_LAST);
    assign addr_d       = addr_q + 1'b1;

    assign in_ready    = (state_q == ST_LOAD) && !xload_done;
    assign valid_input = in_valid && in_ready;
    assign X_load      = valid_input ? in_data : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            r_addr_q    <= '0;
            read_n_q    <= 1'b1;
            alu_en_q    <= 1'b0;
            load_en_q   <= 1'b0;
        end else if (wait_expired) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            err_q       <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            read_n_q    <= 1'b1;
            alu_en_q    <= 1'b0;
            load_en_q   <= 1'b0;
        end else begin
            wait_q <= (waiting && !advance) ? wait_q + 1'b1 : '0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_LOAD;
                        err_q     <= 1'b0;
                        addr_q    <= '0;
                        busy_q    <= 1'b1;
                        load_en_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (xload_done) begin
                        state_q   <= ST_COMPUTE;
                        load_en_q <= 1'b0;
                        alu_en_q  <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (ALU_done) begin
                        state_q  <= ST_RD_REQ;
                        alu_en_q <= 1'b0;
                        read_n_q <= 1'b0;
                        r_addr_q <= addr_q;
                    end
                end
                ST_RD_REQ: begin
                    state_q  <= ST_RD_WAIT;
                    read_n_q <= 1'b1;
                end
                ST_RD_WAIT: begin
                    if (ry) begin
                        state_q     <= ST_OUT;
                        out_data_q  <= data_out;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (addr_q == ADDR_LAST) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_RD_REQ;
                            addr_q   <= addr_d;
                            r_addr_q <= addr_d;
                            read_n_q <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    read_n_q    <= 1'b1;
                    alu_en_q    <= 1'b0;
                    load_en_q   <= 1'b0;
                end
            endcase
        end
    end

    assign input_load_en = load_en_q;
    assign ALU_en        = alu_en_q;
    assign read_n        = read_n_q;
    assign r_addr        = r_addr_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: two instances (4 results and 1 result) share one
// environment; a job-level model supplies every expected byte, address and word.
module tb_matmul_seq_ctrl;

    localparam int TIMEOUT = 1023;
    localparam int ADDR_W  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       xload_done = 1'b0;
    logic       ALU_done = 1'b0;
    logic       ry = 1'b0;
    logic [8:0] data_out = 9'h000;
    logic       out_ready = 1'b1;
    logic       sel = 1'b0;

    logic [1:0]        start_w;
    logic [1:0]        in_ready_w, load_en_w, valid_input_w, alu_en_w, read_n_w;
    logic [1:0]        out_valid_w, busy_w, done_w, err_w;
    logic [7:0]        x_load_w [2];
    logic [ADDR_W-1:0] r_addr_w [2];
    logic [8:0]        out_data_w [2];

    logic              m_in_ready, m_load_en, m_valid_input, m_alu_en, m_read_n;
    logic              m_out_valid, m_busy, m_done, m_err;
    logic [7:0]        m_x_load;
    logic [ADDR_W-1:0] m_r_addr;
    logic [8:0]        m_out_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] mem [0:3];

    always #5 clk = ~clk;

    assign start_w[0] = start && !sel;
    assign start_w[1] = start && sel;

    matmul_seq_ctrl #(.NUM_RESULTS(4), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut4 (
        .clk(clk), .rst(rst), .start(start_w[0]),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[0]),
        .input_load_en(load_en_w[0]), .valid_input(valid_input_w[0]), .X_load(x_load_w[0]),
        .xload_done(xload_done), .ALU_en(alu_en_w[0]), .ALU_done(ALU_done),
        .read_n(read_n_w[0]), .r_addr(r_addr_w[0]), .ry(ry), .data_out(data_out),
        .out_valid(out_valid_w[0]), .out_data(out_data_w[0]), .out_ready(out_ready),
        .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
    );

    matmul_seq_ctrl #(.NUM_RESULTS(1), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w[1]),
        .input_load_en(load_en_w[1]), .valid_input(valid_input_w[1]), .X_load(x_load_w[1]),
        .xload_done(xload_done), .ALU_en(alu_en_w[1]), .ALU_done(ALU_done),
        .read_n(read_n_w[1]), .r_addr(r_addr_w[1]), .ry(ry), .data_out(data_out),
        .out_valid(out_valid_w[1]), .out_data(out_data_w[1]), .out_ready(out_ready),
        .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
    );

    assign m_in_ready    = in_ready_w[sel];
    assign m_load_en     = load_en_w[sel];
    assign m_valid_input = valid_input_w[sel];
    assign m_alu_en      = alu_en_w[sel];
    assign m_read_n      = read_n_w[sel];
    assign m_out_valid   = out_valid_w[sel];
    assign m_busy        = busy_w[sel];
    assign m_done        = done_w[sel];
    assign m_err         = err_w[sel];
    assign m_x_load      = x_load_w[sel];
    assign m_r_addr      = r_addr_w[sel];
    assign m_out_data    = out_data_w[sel];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One complete job seen from the environment. Expectations follow the job rules:
    // every offered byte before xload_done is strobed unchanged, reads walk 0..n_res-1,
    // each word equals the SRAM content at its address, done pulses once at the end.
    task automatic run_job(input int n_res, input bit nominal, input int alu_lat,
                           input bit alu_wide, input bit start_in_compute,
                           input int bp_word, input int bp_cycles, input int rst_word);
        int nb;
        int lat;
        int hold;
        logic [7:0] b;
        for (int a = 0; a < n_res; a++)
            mem[a] = nominal ? 9'(9'h100 + a) : 9'($urandom_range(0, 511));

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_load_en", 32'(m_load_en), 32'd1);
        chk("start_busy", 32'(m_busy), 32'd1);
        chk("start_err_clear", 32'(m_err), 32'd0);
        chk("load_in_ready", 32'(m_in_ready), 32'd1);

        nb = nominal ? 4 : int'($urandom_range(1, 6));
        for (int i = 0; i < nb; i++) begin
            if (!nominal && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                #1;
                chk("gap_strobe", 32'(m_valid_input), 32'd0);
                chk("gap_x_load", 32'(m_x_load), 32'd0);
                tick();
            end
            b = nominal ? 8'(i + 1) : 8'($urandom_range(1, 255));
            in_valid = 1'b1;
            in_data  = b;
            #1;
            chk("byte_strobe", 32'(m_valid_input), 32'd1);
            chk("byte_x_load", 32'(m_x_load), 32'(b));
            $display("byte %0d x_load 0x%02h", i, m_x_load);
            tick();
        end

        // A byte offered in the same cycle as xload_done must not be taken.
        xload_done = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hAA;
        #1;
        chk("full_in_ready", 32'(m_in_ready), 32'd0);
        chk("full_strobe", 32'(m_valid_input), 32'd0);
        chk("full_x_load", 32'(m_x_load), 32'd0);
        tick();
        xload_done = 1'b0;
        in_valid   = 1'b0;
        chk("compute_load_en", 32'(m_load_en), 32'd0);
        chk("compute_alu_en", 32'(m_alu_en), 32'd1);

        for (int c = 0; c < alu_lat; c++) begin
            start = start_in_compute && (c == 1);
            tick();
            start = 1'b0;
            chk("compute_hold_alu_en", 32'(m_alu_en), 32'd1);
            chk("compute_read_n", 32'(m_read_n), 32'd1);
        end
        ALU_done = 1'b1;
        tick();
        ALU_done = alu_wide;
        chk("alu_en_drop", 32'(m_alu_en), 32'd0);

        for (int a = 0; a < n_res; a++) begin
            chk("rd_req_read_n", 32'(m_read_n), 32'd0);
            chk("rd_req_addr", 32'(m_r_addr), 32'(a));
            chk("rd_req_done", 32'(m_done), 32'd0);
            tick();
            ALU_done = 1'b0;
            chk("rd_wait_read_n", 32'(m_read_n), 32'd1);
            chk("rd_wait_addr", 32'(m_r_addr), 32'(a));
            if (rst_word == a) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_read_n", 32'(m_read_n), 32'd1);
                chk("rst_out_valid", 32'(m_out_valid), 32'd0);
                chk("rst_busy", 32'(m_busy), 32'd0);
                chk("rst_r_addr", 32'(m_r_addr), 32'd0);
                $display("async reset during read of word %0d", a);
                tick();
                rst = 1'b1;
                tick();
                return;
            end
            lat = nominal ? 0 : int'($urandom_range(0, 3));
            for (int l = 0; l < lat; l++) begin
                tick();
                chk("ry_wait_out_valid", 32'(m_out_valid), 32'd0);
                chk("ry_wait_read_n", 32'(m_read_n), 32'd1);
            end
            ry       = 1'b1;
            data_out = mem[a];
            tick();
            ry       = 1'b0;
            data_out = 9'($urandom);
            chk("word_valid", 32'(m_out_valid), 32'd1);
            chk("word_data", 32'(m_out_data), 32'(mem[a]));

            hold = (a == bp_word) ? bp_cycles : (nominal ? 0 : int'($urandom_range(0, 2)));
            for (int h = 0; h < hold; h++) begin
                out_ready = 1'b0;
                tick();
                chk("bp_valid", 32'(m_out_valid), 32'd1);
                chk("bp_data", 32'(m_out_data), 32'(mem[a]));
                chk("bp_read_n", 32'(m_read_n), 32'd1);
                chk("bp_err", 32'(m_err), 32'd0);
            end
            out_ready = 1'b1;
            tick();
            chk("handshake_valid_drop", 32'(m_out_valid), 32'd0);
            $display("word %0d r_addr %0d data 0x%03h held %0d", a, a, mem[a], hold);
        end

        chk("done_pulse", 32'(m_done), 32'd1);
        chk("done_busy", 32'(m_busy), 32'd1);
        chk("done_read_n", 32'(m_read_n), 32'd1);
        tick();
        chk("after_done_pulse", 32'(m_done), 32'd0);
        chk("after_done_busy", 32'(m_busy), 32'd0);
        tick();
        chk("idle_no_second_done", 32'(m_done), 32'd0);
        chk("idle_read_n", 32'(m_read_n), 32'd1);
        chk("idle_err", 32'(m_err), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) tick();
        chk("reset_read_n", 32'(m_read_n), 32'd1);
        chk("reset_out_valid", 32'(m_out_valid), 32'd0);
        chk("reset_out_data", 32'(m_out_data), 32'd0);
        chk("reset_r_addr", 32'(m_r_addr), 32'd0);
        chk("reset_busy", 32'(m_busy), 32'd0);
        chk("reset_done", 32'(m_done), 32'd0);
        chk("reset_err", 32'(m_err), 32'd0);
        chk("reset_alu_en", 32'(m_alu_en), 32'd0);
        chk("reset_load_en", 32'(m_load_en), 32'd0);
        chk("reset_in_ready", 32'(m_in_ready), 32'd0);
        chk("reset_x_load", 32'(m_x_load), 32'd0);
        rst = 1'b1;
        tick();

        $display("job: nominal");
        run_job(4, 1'b1, 10, 1'b0, 1'b0, -1, 0, -1);

        $display("job: back-pressure at word 2");
        run_job(4, 1'b0, 3, 1'b0, 1'b0, 2, 50, -1);

        // Timeout: LOAD entered at the edge sampling start; err rises TIMEOUT edges later.
        $display("job: timeout in LOAD");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("timeout_err_low", 32'(m_err), 32'd0);
            chk("timeout_done_low", 32'(m_done), 32'd0);
            tick();
        end
        chk("timeout_err", 32'(m_err), 32'd1);
        chk("timeout_busy", 32'(m_busy), 32'd0);
        chk("timeout_load_en", 32'(m_load_en), 32'd0);
        chk("timeout_in_ready", 32'(m_in_ready), 32'd0);
        chk("timeout_done", 32'(m_done), 32'd0);
        tick();
        chk("timeout_err_sticky", 32'(m_err), 32'd1);
        chk("timeout_no_done", 32'(m_done), 32'd0);

        $display("job: restart after timeout");
        run_job(4, 1'b0, 2, 1'b0, 1'b0, -1, 0, -1);

        $display("job: start during COMPUTE, wide ALU_done");
        run_job(4, 1'b0, 5, 1'b1, 1'b1, -1, 0, -1);

        $display("job: async reset in RD_WAIT");
        run_job(4, 1'b0, 3, 1'b0, 1'b0, -1, 0, 1);
        run_job(4, 1'b0, 3, 1'b0, 1'b0, -1, 0, -1);

        $display("job: single-result instance");
        sel = 1'b1;
        tick();
        run_job(1, 1'b0, 2, 1'b0, 1'b0, -1, 0, -1);
        run_job(1, 1'b0, 4, 1'b1, 1'b0, 0, 3, -1);

        for (int j = 0; j < 4; j++) begin
            sel = j[0];
            tick();
            $display("job: random %0d on instance %0d", j, sel ? 1 : 4);
            run_job(sel ? 1 : 4, 1'b0, int'($urandom_range(2, 8)), 1'($urandom),
                    1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
